text_ram_arbiter: RTL
=====================

Name: text_ram_arbiter

Overview:
- Single-port text RAM scheduler for the 100x60 character display (800x600, 8x10 cells).
- Shares one RAM port between two requesters:
  - the video character fetch, strobed once per cell by clk_load_char from the timing generator;
  - host write requests, buffered in a small FIFO.
- Video fetch has absolute priority. Host writes drain in free cycles.
- Registered character/attribute word is delivered to the font/design stage ahead of clk_load_design.

Parameters:
- TEXT_COLS, 100, characters per row; video address = ytext*TEXT_COLS + xtext.
- TEXT_ROWS, 60, character rows; RAM size = TEXT_COLS*TEXT_ROWS = 6000 words.
- ADDR_WIDTH, 13, RAM address width.
- DATA_WIDTH, 16, RAM word: char code [7:0], attribute [15:8].
- FIFO_DEPTH, 4, host write buffer entries; power of two, >= 2.

Ports:
- clk  in  1  pixel clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- clk_load_char  in  1  video fetch strobe, one cycle per cell.
- xtext  in  7  text column of the strobed cell.
- ytext  in  6  text row of the strobed cell.
- vblank  in  1  high outside vertical drawing area.
- host_valid  in  1  host write request.
- host_addr  in  ADDR_WIDTH  host write address.
- host_data  in  DATA_WIDTH  host write data.
- host_ready  out  1  FIFO can accept a write.
- host_addr_err  out  1  one-cycle pulse: accepted write had host_addr >= 6000 and was dropped.
- ram_addr  out  ADDR_WIDTH  RAM address, registered.
- ram_wdata  out  DATA_WIDTH  RAM write data, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read address.
- char_data  out  DATA_WIDTH  fetched cell word, held until the next fetch.
- char_valid  out  1  one-cycle pulse when char_data updates.

Behaviour:
- Reset values: host_ready=0, host_addr_err=0, ram_addr=0, ram_wdata=0, ram_we=0, char_data=0, char_valid=0. FIFO emptied.
- host_ready: 1 from the first cycle after reset deasserts. Equals (count < FIFO_DEPTH), registered from next-state count.
- Push: host_valid && host_ready.
  - If host_addr >= 6000: the entry is not stored and host_addr_err pulses in the next cycle.
  - Otherwise the entry is stored.
- Per-cycle port FSM, state registered into the RAM outputs:
  - VIDEO_RD, when clk_load_char=1:
    - ram_addr <= ytext*TEXT_COLS + xtext, computed in 13 bits;
    - ram_we <= 0;
    - any host drain this cycle is deferred.
  - HOST_WR, when clk_load_char=0, FIFO not empty and the drain is permitted:
    - ram_addr/ram_wdata <= FIFO head, ram_we <= 1, pop.
  - IDLE, otherwise: ram_we <= 0; ram_addr holds.
- Read pipeline:
  - strobe at cycle N; ram_addr valid at N+1; ram_rdata valid at N+2;
  - char_data <= ram_rdata and char_valid=1 at N+3, i.e. a 3-cycle strobe-to-data latency.
  - Tracked by a 2-bit shift of VIDEO_RD flags. Back-to-back strobes, one cycle apart, must each produce a char_valid.
- Simultaneous push and pop in the same cycle: count unchanged. A push into a full FIFO is impossible because host_ready=0.
- Pointer wrap-around modulo FIFO_DEPTH. FIFO order is preserved.
- xtext/ytext out of range (>= TEXT_COLS / >= TEXT_ROWS) are not checked: the address is computed and truncated to 13 bits.
- Reset mid-operation:
  - pending reads are cancelled and no char_valid is issued;
  - FIFO contents are discarded;
  - a write already on the RAM port for the current cycle completes; ram_we=0 from the next cycle.

Optional Feature:
- Macro: TEXTARB_VBLANK_WRITE_EN.
- Defined: HOST_WR is permitted only while vblank=1. During active display the FIFO fills, host_ready drops at FIFO_DEPTH entries, and there are no mid-frame screen changes.
- Undefined: vblank is ignored and HOST_WR is permitted on any non-strobe cycle.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; host_ready=1 on the first cycle after release.
- RAM preloaded addr 0x0C9 = 0x1F41; strobe with xtext=1, ytext=2 at cycle N -> ram_addr=201 at N+1; char_data=0x1F41 with char_valid=1 at N+3; ram_we stays 0.
- Host write addr 5, data 0xABCD, issued in the same cycle as a strobe -> video read first; write issued the cycle after (ram_we=1, ram_addr=5).
- Five host writes pushed with continuous strobes (macro undefined) -> host_ready=0 after the 4th push; the 5th push is held off; the FIFO drains in order once strobes stop.
- Host write addr 6000 -> host_addr_err pulses one cycle; no RAM write occurs; FIFO count unchanged.
- Macro defined, vblank=0, 2 writes queued -> ram_we stays 0. vblank=1 -> two consecutive writes in FIFO order.

Source files
------------

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM scheduler: video character fetch has absolute priority,
// host writes are buffered in a small FIFO and drained on free cycles.
// Optional build macro TEXTARB_VBLANK_WRITE_EN: host writes drain only while vblank=1.
module text_ram_arbiter #(
  parameter int unsigned TEXT_COLS  = 100,
  parameter int unsigned TEXT_ROWS  = 60,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_load_char,
  input  logic [6:0]            xtext,
  input  logic [5:0]            ytext,
  input  logic                  vblank,
  input  logic                  host_valid,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ready,
  output logic                  host_addr_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] char_data,
  output logic                  char_valid
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned RamWords = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned EntryW   = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StVideoRd, StHostWr} port_op_e;

  port_op_e              op_d;
  logic [EntryW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  host_ready_q, host_ready_d;
  logic                  addr_err_q, addr_err_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic [1:0]            rd_pipe_q, rd_pipe_d;
  logic [DATA_WIDTH-1:0] char_data_q, char_data_d;
  logic                  char_valid_q, char_valid_d;

  logic                  push, addr_ok, store, pop, fifo_empty, drain_ok;
  logic [ADDR_WIDTH-1:0] video_addr;
  logic [EntryW-1:0]     head;

`ifdef TEXTARB_VBLANK_WRITE_EN
  assign drain_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign drain_ok      = 1'b1;
`endif

  // Out-of-range cells are not checked; the product simply truncates.
  assign video_addr = ADDR_WIDTH'(ADDR_WIDTH'(ytext) * ADDR_WIDTH'(TEXT_COLS))
                    + ADDR_WIDTH'(xtext);
  assign push       = host_valid && host_ready_q;
  assign addr_ok    = host_addr < ADDR_WIDTH'(RamWords);
  assign store      = push && addr_ok;
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign pop        = (op_d == StHostWr);

  // Port arbitration: strobe wins, otherwise drain the FIFO head if allowed.
  always_comb begin
    op_d = StIdle;
    if (clk_load_char) begin
      op_d = StVideoRd;
    end else if (!fifo_empty && drain_ok) begin
      op_d = StHostWr;
    end
  end

  // FIFO bookkeeping and host-side flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({store, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    host_ready_d = (count_d < CntW'(FIFO_DEPTH));
    addr_err_d   = push && !addr_ok;
  end

  // RAM port next-state and the read-return pipeline.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    unique case (op_d)
      StVideoRd: ram_addr_d = video_addr;
      StHostWr: begin
        ram_addr_d  = head[EntryW-1:DATA_WIDTH];
        ram_wdata_d = head[DATA_WIDTH-1:0];
        ram_we_d    = 1'b1;
      end
      default: ;
    endcase
    // Bit 0: address on the port this cycle; bit 1: read data on ram_rdata.
    rd_pipe_d    = {rd_pipe_q[0], op_d == StVideoRd};
    char_valid_d = rd_pipe_q[1];
    char_data_d  = rd_pipe_q[1] ? ram_rdata : char_data_q;
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (store) fifo_q[wr_ptr_q] <= {host_addr, host_data};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      host_ready_q <= 1'b0;
      addr_err_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      rd_pipe_q    <= '0;
      char_data_q  <= '0;
      char_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      host_ready_q <= host_ready_d;
      addr_err_q   <= addr_err_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_we_q     <= ram_we_d;
      rd_pipe_q    <= rd_pipe_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
    end
  end

  assign host_ready    = host_ready_q;
  assign host_addr_err = addr_err_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign char_data     = char_data_q;
  assign char_valid    = char_valid_q;

endmodule
